// File: rtl/pipe_arb_pkg.sv
// Shared types and constants for the pipeline data-memory arbiter.
package pipe_arb_pkg;

   typedef enum logic {
      S_CPU  = 1'b0,
      S_LOCK = 1'b1
   } arbState_t;

   localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/pipe_arb_perf.sv
// Performance counters for the data-memory arbiter: stalled cycles and debug grants.
// Instantiated by pipe_dmem_arbiter only when DMEM_ARB_PERF_EN is defined.
module pipe_arb_perf (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        gnt_i,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] dbg_cnt_o
);

   logic [31:0] stallCnt_q;
   logic [31:0] dbgCnt_q;

   // Both counters wrap naturally at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         stallCnt_q <= '0;
         dbgCnt_q   <= '0;
      end else begin
         if (stall_i) stallCnt_q <= stallCnt_q + 32'd1;
         if (gnt_i)   dbgCnt_q   <= dbgCnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stallCnt_q;
   assign dbg_cnt_o   = dbgCnt_q;

endmodule

// File: rtl/pipe_dmem_arbiter.sv
// Arbitrates the synchronous data RAM between the MEM stage and a debug/loader port.
// Define DMEM_ARB_PERF_EN to build the stall/grant performance counters.
module pipe_dmem_arbiter
   import pipe_arb_pkg::*;
#(
   parameter int WAIT_MAX = 8,
   parameter int LOCK_MAX = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic        dbg_lock,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_dbg_cnt
);

   localparam logic [ARB_CNT_W-1:0] WAIT_LIM = ARB_CNT_W'(WAIT_MAX);
   localparam logic [ARB_CNT_W-1:0] LOCK_LIM = ARB_CNT_W'(LOCK_MAX);

   arbState_t            state_q, state_d;
   logic [ARB_CNT_W-1:0] waitCnt_q, waitCnt_d;
   logic [ARB_CNT_W-1:0] lockCnt_q, lockCnt_d;
   logic                 dbgOwn;
   logic                 dbgRvalid_q;
   logic [31:0]          dbgRdata_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_CPU;
         waitCnt_q <= '0;
         lockCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         lockCnt_q <= lockCnt_d;
      end
   end

   // Ownership decision; the CPU keeps the RAM unless debug has waited long enough.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      lockCnt_d = lockCnt_q;
      dbgOwn    = 1'b0;
      unique case (state_q)
         S_CPU: begin
            if (!dbg_req) begin
               waitCnt_d = '0;
            end else if (!cpu_req) begin
               dbgOwn    = 1'b1;
               waitCnt_d = '0;
            end else if (waitCnt_q < WAIT_LIM) begin
               waitCnt_d = waitCnt_q + 1'b1;
            end else begin
               dbgOwn    = 1'b1;
               waitCnt_d = '0;
            end
            if (dbgOwn && dbg_lock) begin
               state_d   = S_LOCK;
               lockCnt_d = 8'd1;
            end
         end
         S_LOCK: begin
            if (dbg_req && dbg_lock && (lockCnt_q < LOCK_LIM)) begin
               dbgOwn    = 1'b1;
               lockCnt_d = lockCnt_q + 1'b1;
            end else begin
               state_d   = S_CPU;
               waitCnt_d = '0;
               lockCnt_d = '0;
            end
         end
         default: state_d = S_CPU;
      endcase
   end

   // Grant, stall and write enable are forced low while reset is held.
   assign dbg_gnt   = dbgOwn && !reset;
   assign cpu_stall = dbg_gnt && cpu_req;
   assign ram_we    = !reset && (dbgOwn ? dbg_we : (cpu_req && cpu_we));
   assign ram_addr  = dbgOwn ? dbg_addr  : cpu_addr;
   assign ram_wdata = dbgOwn ? dbg_wdata : cpu_wdata;
   assign cpu_rdata = ram_rdata;

   always_ff @(posedge clock) begin
      if (reset) begin
         dbgRvalid_q <= 1'b0;
         dbgRdata_q  <= '0;
      end else begin
         dbgRvalid_q <= dbg_gnt && !dbg_we;
         if (dbg_gnt && !dbg_we) dbgRdata_q <= ram_rdata;
      end
   end

   assign dbg_rvalid = dbgRvalid_q;
   assign dbg_rdata  = dbgRdata_q;

`ifdef DMEM_ARB_PERF_EN
   pipe_arb_perf uPerf (
      .clock       (clock),
      .reset       (reset),
      .stall_i     (cpu_stall),
      .gnt_i       (dbg_gnt),
      .stall_cnt_o (perf_stall_cnt),
      .dbg_cnt_o   (perf_dbg_cnt)
   );
`else
   assign perf_stall_cnt = '0;
   assign perf_dbg_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// Directed self-checking bench for pipe_dmem_arbiter with a behavioural RAM clocked by ~clock.
module tb_pipe_dmem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [31:0] perf_stall_cnt, perf_dbg_cnt;

   int compareCount  = 0;
   int mismatchCount = 0;

   logic [31:0] mem [0:255];

   pipe_dmem_arbiter #(.WAIT_MAX(8), .LOCK_MAX(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdata      (cpu_rdata),
      .cpu_stall      (cpu_stall),
      .dbg_req        (dbg_req),
      .dbg_we         (dbg_we),
      .dbg_lock       (dbg_lock),
      .dbg_addr       (dbg_addr),
      .dbg_wdata      (dbg_wdata),
      .dbg_gnt        (dbg_gnt),
      .dbg_rvalid     (dbg_rvalid),
      .dbg_rdata      (dbg_rdata),
      .ram_we         (ram_we),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_dbg_cnt   (perf_dbg_cnt)
   );

   always #5 clock = ~clock;

   // RAM writes on the falling edge so data is readable later in the same cycle.
   assign ram_rdata = mem[ram_addr[9:2]];
   always @(negedge clock) begin
      if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic idleInputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0;
   endtask

   task automatic pulseReset();
      idleInputs();
      reset = 1;
      applyStimulus();
      reset = 0;
   endtask

   logic [31:0] perfOn;
   logic        expG;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
`ifdef DMEM_ARB_PERF_EN
      perfOn = 32'd1;
`else
      perfOn = 32'd0;
`endif
      idleInputs();
      reset = 1;

      // Outputs gated while reset is held, even with both sides requesting writes.
      applyStimulus();
      cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1;
      #1;
      checkOutput("rst_gnt",   {31'b0, dbg_gnt},   32'd0);
      checkOutput("rst_stall", {31'b0, cpu_stall}, 32'd0);
      checkOutput("rst_we",    {31'b0, ram_we},    32'd0);
      applyStimulus();
      idleInputs();
      reset = 0;
      #1;
      checkOutput("rst_rvalid", {31'b0, dbg_rvalid}, 32'd0);
      checkOutput("rst_rdata",  dbg_rdata,           32'd0);
      checkOutput("rst_pstall", perf_stall_cnt,      32'd0);
      checkOutput("rst_pdbg",   perf_dbg_cnt,        32'd0);

      // CPU only: store then load.
      applyStimulus();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      #1;
      checkOutput("cpu_st_we",    {31'b0, ram_we},    32'd1);
      checkOutput("cpu_st_stall", {31'b0, cpu_stall}, 32'd0);
      checkOutput("cpu_st_gnt",   {31'b0, dbg_gnt},   32'd0);
      applyStimulus();
      cpu_we = 0;
      #1;
      checkOutput("cpu_ld_data",  cpu_rdata,          32'hDEADBEEF);
      checkOutput("cpu_ld_stall", {31'b0, cpu_stall}, 32'd0);
      checkOutput("cpu_ld_gnt",   {31'b0, dbg_gnt},   32'd0);

      // Debug only: write granted immediately, read returns a cycle later.
      applyStimulus();
      idleInputs();
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
      #1;
      checkOutput("dbg_wr_gnt", {31'b0, dbg_gnt}, 32'd1);
      checkOutput("dbg_wr_we",  {31'b0, ram_we},  32'd1);
      applyStimulus();
      dbg_we = 0;
      #1;
      checkOutput("dbg_rd_gnt",    {31'b0, dbg_gnt},    32'd1);
      checkOutput("dbg_rd_we",     {31'b0, ram_we},     32'd0);
      checkOutput("dbg_wr_norval", {31'b0, dbg_rvalid}, 32'd0);
      applyStimulus();
      dbg_req = 0;
      #1;
      checkOutput("dbg_rd_rvalid", {31'b0, dbg_rvalid}, 32'd1);
      checkOutput("dbg_rd_rdata",  dbg_rdata,           32'h12345678);
      applyStimulus();
      #1;
      checkOutput("dbg_rval_drop", {31'b0, dbg_rvalid}, 32'd0);
      checkOutput("dbg_rdata_hold", dbg_rdata,          32'h12345678);

      // Starvation: debug forced through on cycle 8.
      pulseReset();
      cpu_req = 1; cpu_addr = 32'h10;
      dbg_req = 1; dbg_addr = 32'h20;
      for (int k = 0; k < 10; k++) begin
         if (k == 9) dbg_req = 0;
         #1;
         expG = (k == 8);
         checkOutput($sformatf("starve_gnt%0d", k),   {31'b0, dbg_gnt},   {31'b0, expG});
         checkOutput($sformatf("starve_stall%0d", k), {31'b0, cpu_stall}, {31'b0, expG});
         checkOutput($sformatf("starve_addr%0d", k),  ram_addr, expG ? 32'h20 : 32'h10);
         if (k == 9) begin
            checkOutput("starve_rvalid", {31'b0, dbg_rvalid}, 32'd1);
            checkOutput("starve_rdata",  dbg_rdata,           32'h12345678);
            checkOutput("starve_cpu",    cpu_rdata,           32'hDEADBEEF);
            checkOutput("starve_pstall", perf_stall_cnt,      perfOn);
            checkOutput("starve_pdbg",   perf_dbg_cnt,        perfOn);
         end
         applyStimulus();
      end

      // Locked burst: 4 stalled grants after the wait expires, then CPU again.
      cpu_req = 1; dbg_req = 1; dbg_lock = 1; dbg_we = 1;
      dbg_addr = 32'h30; dbg_wdata = 32'hA5A5A5A5;
      for (int k = 0; k < 14; k++) begin
         #1;
         expG = (k >= 8) && (k <= 11);
         checkOutput($sformatf("lock_gnt%0d", k),   {31'b0, dbg_gnt},   {31'b0, expG});
         checkOutput($sformatf("lock_stall%0d", k), {31'b0, cpu_stall}, {31'b0, expG});
         applyStimulus();
      end
      checkOutput("lock_pstall", perf_stall_cnt, 32'd5 & {32{perfOn[0]}});
      checkOutput("lock_pdbg",   perf_dbg_cnt,   32'd5 & {32{perfOn[0]}});
      checkOutput("lock_mem",    mem[8'h0C],     32'hA5A5A5A5);

      // Reset while locked after two read grants.
      idleInputs();
      dbg_req = 1; dbg_lock = 1; dbg_addr = 32'h20;
      #1;
      checkOutput("rlk_gnt0", {31'b0, dbg_gnt}, 32'd1);
      applyStimulus();
      #1;
      checkOutput("rlk_gnt1", {31'b0, dbg_gnt}, 32'd1);
      applyStimulus();
      reset = 1;
      #1;
      checkOutput("rlk_rvalid_pre", {31'b0, dbg_rvalid}, 32'd1);
      checkOutput("rlk_gnt_rst",    {31'b0, dbg_gnt},    32'd0);
      applyStimulus();
      reset = 0; cpu_req = 1;
      #1;
      checkOutput("rlk_cpu_wins", {31'b0, dbg_gnt},    32'd0);
      checkOutput("rlk_rvalid",   {31'b0, dbg_rvalid}, 32'd0);
      checkOutput("rlk_pstall",   perf_stall_cnt,      32'd0);
      checkOutput("rlk_pdbg",     perf_dbg_cnt,        32'd0);
      applyStimulus();
      idleInputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
